// File: rtl/port_stream_device.sv
// CPU I/O port peripheral bridging port writes/reads to two 16-bit valid/ready
// streams: an outbound FIFO fed by CPU PUSH commands and an inbound FIFO drained by CPU reads.
module port_stream_device #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0][15:0] port_d_out,
    input  logic             port_inform_write,
    input  logic             port_inform_read,
    output logic [1:0][15:0] port_d_in,
    input  logic [15:0]      host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [15:0]      host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [15:0] CMD_PUSH   = 16'h0001;
    localparam logic [15:0] CMD_FLUSH  = 16'h0002;
    localparam logic [15:0] CMD_CLRERR = 16'h0003;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [15:0]      out_mem [DEPTH];
    logic [15:0]      in_mem  [DEPTH];
    logic [PTR_W-1:0] out_wr, out_rd, in_wr, in_rd;
    logic [CNT_W-1:0] out_cnt, in_cnt;
    logic             ovf, unf, badcmd;

    logic cmd_push, cmd_flush, cmd_clrerr, cmd_bad;
    logic out_empty, out_full, in_empty, in_full;
    logic out_push, out_pop, in_push, in_pop;
    logic ovf_evt, unf_evt;

    always_comb begin
        cmd_push   = port_inform_write && (port_d_out[1] == CMD_PUSH);
        cmd_flush  = port_inform_write && (port_d_out[1] == CMD_FLUSH);
        cmd_clrerr = port_inform_write && (port_d_out[1] == CMD_CLRERR);
        cmd_bad    = port_inform_write && !(cmd_push || cmd_flush || cmd_clrerr);

        out_empty  = (out_cnt == '0);
        out_full   = (out_cnt == FULL_CNT);
        in_empty   = (in_cnt == '0);
        in_full    = (in_cnt == FULL_CNT);

        // A host pop frees a slot in the same cycle, so a PUSH into a full FIFO still lands.
        out_pop    = host_out_ready && !out_empty;
        out_push   = cmd_push && (!out_full || out_pop);
        ovf_evt    = cmd_push && out_full && !out_pop;

        in_push    = host_in_valid && !in_full;
        in_pop     = port_inform_read && !in_empty;
        unf_evt    = port_inform_read && in_empty && !cmd_flush;
    end

    // FLUSH overrides every same-cycle push and pop; handshakes still complete on the wire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_wr  <= '0;
            out_rd  <= '0;
            out_cnt <= '0;
            in_wr   <= '0;
            in_rd   <= '0;
            in_cnt  <= '0;
        end else if (cmd_flush) begin
            out_wr  <= '0;
            out_rd  <= '0;
            out_cnt <= '0;
            in_wr   <= '0;
            in_rd   <= '0;
            in_cnt  <= '0;
        end else begin
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            if (in_push)  in_wr  <= in_wr + 1'b1;
            if (in_pop)   in_rd  <= in_rd + 1'b1;
            out_cnt <= out_cnt + CNT_W'(out_push) - CNT_W'(out_pop);
            in_cnt  <= in_cnt + CNT_W'(in_push) - CNT_W'(in_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !cmd_flush) begin
            if (out_push) out_mem[out_wr] <= port_d_out[0];
            if (in_push)  in_mem[in_wr]   <= host_in_data;
        end
    end

    // A new error event wins over a same-cycle CLRERR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf    <= 1'b0;
            unf    <= 1'b0;
            badcmd <= 1'b0;
        end else begin
            ovf    <= (ovf && !cmd_clrerr) || ovf_evt;
            unf    <= (unf && !cmd_clrerr) || unf_evt;
            badcmd <= (badcmd && !cmd_clrerr) || cmd_bad;
        end
    end

    always_comb begin
        host_out_valid = !out_empty;
        host_out_data  = out_empty ? 16'h0000 : out_mem[out_rd];
        host_in_ready  = !in_full;
        port_d_in[0]   = in_empty ? 16'h0000 : in_mem[in_rd];
        port_d_in[1]   = {8'(in_cnt), 3'b000, badcmd, unf, ovf, out_full, !in_empty};
    end

endmodule

// File: doc/port_stream_device.md
Name: port_stream_device

Overview:
- Peripheral on one CPU I/O port pair; responds to CPU port writes and reads.
- Converts CPU port traffic into two 16-bit valid/ready streams toward a host-side agent:
  - an outbound FIFO filled by CPU writes;
  - an inbound FIFO drained by CPU reads.
- Instantiated once per used port index p; connects to CPU words 2p and 2p+1 plus port_inform_write[p] and port_inform_read[p].

Parameters:
- DEPTH, 8, entries per FIFO; power of two, 2..128.
- CNT_W, $clog2(DEPTH)+1, width of the internal occupancy counters.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- port_d_out  input  16 x 2  CPU write words; [0] = data, [1] = command.
- port_inform_write  input  1  one-cycle pulse; CPU has written this port.
- port_inform_read  input  1  one-cycle pulse; CPU has consumed this port.
- port_d_in  output  16 x 2  CPU read words; [0] = inbound head data, [1] = status.
- host_in_data  input  16  inbound stream data.
- host_in_valid  input  1  inbound data valid.
- host_in_ready  output  1  inbound FIFO can accept.
- host_out_data  output  16  outbound stream data.
- host_out_valid  output  1  outbound FIFO non-empty.
- host_out_ready  input  1  host consumes outbound head.

Behaviour:
- Reset (rst_n=0 at edge):
  - pointers and counts = 0; sticky flags = 0.
  - port_d_in[0] = 0; port_d_in[1] = 0x0000; host_out_valid = 0; host_in_ready = 1.
  - Reset mid-operation discards all FIFO contents; no partial transfers complete.
- Commands are sampled when port_inform_write=1 and are decoded from port_d_out[1]:
  - 0x0001 PUSH: enqueue port_d_out[0] into the outbound FIFO.
  - 0x0002 FLUSH: empty both FIFOs.
  - 0x0003 CLRERR: clear the sticky flags.
  - Any other code: no-op. It sets the BADCMD sticky flag.
- Status word port_d_in[1]:
  - bit0 = inbound non-empty; bit1 = outbound full.
  - bit2 = OVF sticky: a PUSH was dropped because the outbound FIFO was full.
  - bit3 = UNF sticky: a read was made with the inbound FIFO empty.
  - bit4 = BADCMD sticky.
  - bits[15:8] = inbound count; bits[7:5] = 0.
- port_d_in[0]: inbound head entry when non-empty, else 0x0000.
- All outputs derive from registered state only; there is no combinational path from any input to any output.
- Read pop: port_inform_read=1 pops the inbound head if non-empty, otherwise sets UNF. The next head is visible on port_d_in the cycle after the edge.
- Host inbound push: host_in_valid & host_in_ready at an edge enqueues host_in_data. host_in_ready = (inbound count != DEPTH).
- Host outbound pop: host_out_valid & host_out_ready pops the outbound head. host_out_data = outbound head (0 when empty).
- Latency:
  - A CPU PUSH at edge N gives host_out_valid=1 from after edge N.
  - A host push at edge N gives status bit0=1 and data on port_d_in[0] after edge N.
- Simultaneous events:
  - Outbound full, PUSH and host pop in the same cycle: both occur, count unchanged, no OVF.
  - Outbound full, PUSH without host pop: data dropped, OVF set, contents unchanged.
  - Inbound: a host push (allowed only when not full) and a CPU pop in the same cycle both occur.
  - FLUSH takes priority over every same-cycle push/pop on both FIFOs:
    - host handshakes in that cycle complete but their data is discarded;
    - a same-cycle port_inform_read does not set UNF.
  - CLRERR in the same cycle as a new error event: the flag ends set (set wins).
  - port_inform_write and port_inform_read in the same cycle are processed independently.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is determined by the counters, never by pointer equality.

Test Plan:
- Reset, then idle 5 cycles -> port_d_in[0]=0x0000, port_d_in[1]=0x0000, host_out_valid=0, host_in_ready=1.
- PUSH 0x00AA, 0x00BB, 0x00CC with host_out_ready=0, then host_out_ready=1 -> host pops AA, BB, CC in order; host_out_valid drops after the third pop.
- Host pushes 0x1234, 0x5678 -> status reads 0x0201, port_d_in[0]=0x1234. One read pulse -> 0x5678, status 0x0101. Second read -> status 0x0000. Third read -> status 0x0008 (UNF).
- DEPTH=8: 9 PUSHes with host_out_ready=0 -> status bit1=1 and bit2=1; the host receives exactly the first 8 values. CLRERR -> bit2=0, bit1 stays 1.
- Outbound full, PUSH 0xBEEF with host_out_ready=1 in the same cycle -> no OVF; 0xBEEF emerges 8th. Command 0x0007 -> bit4=1.
- Fill both FIFOs partially, issue FLUSH together with a host_in push -> both empty next cycle, status 0x0000 (apart from prior stickies); pushed word not present. Reset asserted mid-stream -> all state cleared.
